// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with valid/ready handshakes on both sides.
// An accepted operation (a + b + cin) is computed one bit per cycle, LSB first,
// over exactly WIDTH cycles, then held in DONE until the consumer takes it.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - a, b, cin are valid
//   in_ready  - block can accept an operation (IDLE)
//   a, b      - WIDTH-bit addends
//   cin       - carry-in to bit 0
//   out_valid - sum/cout valid (DONE)
//   out_ready - consumer accepts the result
//   sum       - registered result, a+b+cin mod 2^WIDTH
//   cout      - registered carry-out of bit WIDTH-1
//   busy      - high in RUN and DONE
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cout_q;
  logic [CntW-1:0]  cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_shift;

  // One full-adder slice on the current operand LSBs.
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
  end

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in res_q[0].
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = bit_s;
  end else begin : g_res_wn
    assign res_shift = {bit_s, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_shift;
          carry_q <= bit_c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_q      <= bit_c;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          // Hand-off returns to IDLE only; a new accept needs a further edge.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = res_q;
  assign cout      = cout_q;

endmodule
